spi_slave_bridge: RTL and testbench
===================================

SPI_SLAVE_BRIDGE -- requirements
Module: spi_slave_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on spi_cs/spi_clk/spi_din (range 2..3).
REQ-002 SHALL have parameter CMD_WR, default 8'h02: write command code.
REQ-003 SHALL have parameter CMD_RD, default 8'h0B: read command code.
REQ-004 clk  in  1  system clock, all logic single-domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 spi_cs  in  1  chip select from master, active-low.
REQ-007 spi_clk  in  1  serial clock, idle high.
REQ-008 spi_din  in  1  master-to-slave data, MSB first.
REQ-009 spi_dout  out  1  slave-to-master data, MSB first.
REQ-010 bus_req  out  1  bus request, held until bus_ack.
REQ-011 bus_we  out  1  1 = write, 0 = read, valid with bus_req.
REQ-012 bus_addr  out  32  byte address, valid with bus_req.
REQ-013 bus_wdata  out  32  write data, valid with bus_req.
REQ-014 bus_rdata  in  32  read data, valid when bus_ack=1 and bus_we=0.
REQ-015 bus_ack  in  1  single-cycle completion pulse.
REQ-016 rd_late  out  1  sticky: read data not ready before first data-phase falling edge.

Function
REQ-017 Inputs SHALL pass through SYNC_STAGES flops; rise/fall of spi_clk detected from synchronized copy, one-clk pulses.
REQ-018 spi_din SHALL be sampled on synchronized spi_clk rising edge; spi_dout SHALL update on falling edge.
REQ-019 FSM states IDLE, CMD, ADDR, DATA, DRAIN; IDLE -> CMD on synchronized spi_cs falling.
REQ-020 CMD: 8 bits into cmd register, then ADDR; if code is neither CMD_WR nor CMD_RD, go DRAIN.
REQ-021 ADDR: 32 bits into bus_addr, then DATA.
REQ-022 DATA write: every 32 bits, bus_req=1, bus_we=1, bus_wdata=word; after bus_ack, bus_addr += 4 (wraps at 2^32).
REQ-023 DATA read: bus_req issued the clk after 40th bit; bus_rdata captured on bus_ack into shift register; address += 4 and next read issued on each word's 32nd rising edge.
REQ-024 If shift register not loaded at first falling edge of a read word, spi_dout SHALL send 0 for that word and rd_late SHALL set.
REQ-025 Write word completing while previous bus_req is pending SHALL be dropped and rd_late unaffected; bus_req never deasserts before bus_ack.
REQ-026 Synchronized spi_cs rising in any state SHALL return FSM to IDLE; partial words discarded; pending bus_req still held until bus_ack.
REQ-027 DRAIN: ignore spi_clk, spi_dout=0, until spi_cs rises.
REQ-028 spi_dout SHALL be 0 outside DATA-read.
REQ-029 rd_late clears only on reset.

Reset
REQ-030 rst_n low SHALL force FSM IDLE, bit counter 0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, spi_dout=0, rd_late=0, synchronizers to idle (spi_cs=1, spi_clk=1).
REQ-031 Reset mid-frame SHALL abandon the frame; the next access starts only after a fresh spi_cs falling edge.

Configuration
REQ-032 Macro SPI_SLAVE_READ_EN defined: CMD_RD supported per REQ-023/024.
REQ-033 Macro undefined: CMD_RD treated as unknown (DRAIN), bus_we tied 1 when bus_req, rd_late tied 0, read logic absent.

Verification
REQ-034 Write frame 02, 0000_1000, DEADBEEF, CAFEF00D -> bus writes 0x1000=DEADBEEF, 0x1004=CAFEF00D, bus_we=1.
REQ-035 Read frame 0B, 0000_2000, 64 clocks; bus_ack at 2 clk returning 12345678 then 9ABCDEF0 -> spi_dout streams 12345678, 9ABCDEF0; rd_late=0.
REQ-036 Read with bus_ack delayed past first data falling edge -> word 0 reads 00000000, rd_late=1.
REQ-037 Command 0x55 + 64 bits -> no bus_req, spi_dout=0, FSM IDLE after spi_cs high.
REQ-038 spi_cs high after 20 data bits of a write -> no bus_req; next frame 02, 0000_0000, 00000001 writes correctly.
REQ-039 Write at address FFFF_FFFC, two words -> second write at 0000_0000.

Source files
------------

// File: rtl/spi_slave_bridge.sv
// SPI (mode 3, idle-high clock) slave that turns command/address/data frames into 32-bit bus accesses.
// Read support is compiled in only when SPI_SLAVE_READ_EN is defined; the default build is write-only.
`timescale 1ns/1ps
module spi_slave_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_WR      = 8'h02,
  parameter logic [7:0]  CMD_RD      = 8'h0B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs,
  input  logic        spi_clk,
  input  logic        spi_din,
  output logic        spi_dout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        rd_late
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q, fill_q;
  logic                   cs_prev_q, sclk_prev_q, armed_q;
  logic [4:0]             cnt_q;
  logic [30:0]            sh_q;
  logic [7:0]             cmd_q;
  logic                   bus_req_q, bus_we_q;
  logic [31:0]            bus_addr_q, bus_wdata_q;

  logic        cs_s, sclk_s, din_s, cs_rise, cs_fall, sclk_rise;
  logic [31:0] shift_in;
  logic        wr_mode, cmd_ok;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign shift_in  = {sh_q, din_s};
  assign wr_mode   = (cmd_q == CMD_WR);

`ifdef SPI_SLAVE_READ_EN
  logic        sclk_fall, rd_issue_q, rvld_q, skip_q, dout_q, rd_late_q;
  logic [31:0] rbuf_q, tx_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cmd_ok    = (shift_in[7:0] == CMD_WR) || (shift_in[7:0] == CMD_RD);
  assign spi_dout  = dout_q;
  assign rd_late   = rd_late_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus_rdata;
  assign cmd_ok       = (shift_in[7:0] == CMD_WR);
  assign spi_dout     = 1'b0;
  assign rd_late      = 1'b0;
`endif

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall && armed_q) state_d = CMD;
      CMD:     if (sclk_rise && cnt_q == 5'd7) state_d = cmd_ok ? ADDR : DRAIN;
      ADDR:    if (sclk_rise && cnt_q == 5'd31) state_d = DATA;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      din_sync_q  <= '0;
      fill_q      <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      cmd_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
`ifdef SPI_SLAVE_READ_EN
      rd_issue_q  <= 1'b0;
      rvld_q      <= 1'b0;
      skip_q      <= 1'b0;
      dout_q      <= 1'b0;
      rd_late_q   <= 1'b0;
      rbuf_q      <= '0;
      tx_q        <= '0;
`endif
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      // A chip select already low when reset lifts must not look like a new frame.
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

      if (bus_ack) begin
        bus_req_q <= 1'b0;
        if (bus_we_q) bus_addr_q <= bus_addr_q + 32'd4;
`ifdef SPI_SLAVE_READ_EN
        else if (skip_q) skip_q <= 1'b0;
        else begin
          rbuf_q <= bus_rdata;
          rvld_q <= 1'b1;
        end
`endif
      end

`ifdef SPI_SLAVE_READ_EN
      if (rd_issue_q && !bus_req_q) begin
        rd_issue_q <= 1'b0;
        bus_req_q  <= 1'b1;
        bus_we_q   <= 1'b0;
      end
`endif

      if (sclk_rise && (state_q inside {CMD, ADDR, DATA})) begin
        sh_q  <= shift_in[30:0];
        cnt_q <= cnt_q + 5'd1;
      end

      if (sclk_rise && state_q == CMD && cnt_q == 5'd7) begin
        cmd_q <= shift_in[7:0];
        cnt_q <= '0;
      end

      if (sclk_rise && state_q == ADDR && cnt_q == 5'd31) begin
        bus_addr_q <= shift_in;
        cnt_q      <= '0;
`ifdef SPI_SLAVE_READ_EN
        if (!wr_mode) rd_issue_q <= 1'b1;
`endif
      end

      // A word finishing while the bus is still busy is dropped.
      if (sclk_rise && state_q == DATA && cnt_q == 5'd31 && !bus_req_q) begin
        if (wr_mode) begin
          bus_req_q   <= 1'b1;
          bus_we_q    <= 1'b1;
          bus_wdata_q <= shift_in;
        end
`ifdef SPI_SLAVE_READ_EN
        else begin
          bus_req_q  <= 1'b1;
          bus_we_q   <= 1'b0;
          bus_addr_q <= bus_addr_q + 32'd4;
        end
`endif
      end

`ifdef SPI_SLAVE_READ_EN
      if (state_q == DATA && !wr_mode) begin
        if (sclk_fall) begin
          if (cnt_q == 5'd0) begin
            // Data that misses the word's first bit is sent as zeros; its late ack is discarded.
            if (rvld_q) begin
              dout_q <= rbuf_q[31];
              tx_q   <= {rbuf_q[30:0], 1'b0};
            end else begin
              dout_q    <= 1'b0;
              tx_q      <= '0;
              rd_late_q <= 1'b1;
              skip_q    <= bus_req_q & ~bus_ack;
            end
            rvld_q <= 1'b0;
          end else begin
            dout_q <= tx_q[31];
            tx_q   <= {tx_q[30:0], 1'b0};
          end
        end
      end else begin
        dout_q <= 1'b0;
      end
`endif

      if (cs_rise) begin
        cnt_q <= '0;
`ifdef SPI_SLAVE_READ_EN
        dout_q     <= 1'b0;
        rd_issue_q <= 1'b0;
`endif
      end

      if (cs_fall && armed_q && state_q == IDLE) begin
        cnt_q <= '0;
`ifdef SPI_SLAVE_READ_EN
        rvld_q <= 1'b0;
        skip_q <= bus_req_q & ~bus_we_q & ~bus_ack;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: bit-banged SPI master plus an acking bus responder.
`timescale 1ns/1ps
module tb_spi_slave_bridge;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_cs = 1'b1, spi_clk = 1'b1, spi_din = 1'b0;
  logic        spi_dout, bus_req, bus_we, rd_late;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  logic [31:0] rd_data [0:7];
  int          rd_idx = 0;
  bit          late_next = 1'b0;
  int          dly;
  int          base;
  logic [127:0] rx;

  spi_slave_bridge dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_din(spi_din),
    .spi_dout(spi_dout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .rd_late(rd_late)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [127:0] d, input int n, output logic [127:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_clk = 1'b0;
      spi_din = d[i];
      repeat (H) @(negedge clk);
      r = {r[126:0], spi_dout};
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic spi_frame(input logic [127:0] d, input int n, output logic [127:0] r);
    spi_cs = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(d, n, r);
    repeat (H) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  // Bus responder: acks every request after a short delay, optionally one long delay.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_req) begin
        dly = late_next ? 30 : 2;
        late_next = 1'b0;
        repeat (dly - 1) @(negedge clk);
        log_addr.push_back(bus_addr);
        log_we.push_back(bus_we);
        log_data.push_back(bus_wdata);
        if (!bus_we) begin
          bus_rdata = rd_data[rd_idx % 8];
          rd_idx++;
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
  end

  initial begin
    rd_data[0] = 32'h12345678; rd_data[1] = 32'h9ABCDEF0; rd_data[2] = 32'h55555555;
    rd_data[3] = 32'hAAAA5555; rd_data[4] = 32'h0F0F0F0F; rd_data[5] = 32'h33333333;
    rd_data[6] = 32'h0;        rd_data[7] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_req",   {63'd0, bus_req}, 64'd0);
    chk("rst_we",    {63'd0, bus_we}, 64'd0);
    chk("rst_addr",  {32'd0, bus_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus_wdata}, 64'd0);
    chk("rst_dout",  {63'd0, spi_dout}, 64'd0);
    chk("rst_late",  {63'd0, rd_late}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Two-word write burst
    base = log_addr.size();
    spi_frame({24'd0, 8'h02, 32'h0000_1000, 64'hDEADBEEF_CAFEF00D}, 104, rx);
    chk("wr_cnt",   64'(log_addr.size() - base), 64'd2);
    if (log_addr.size() >= base + 2) begin
      chk("wr0_addr", {32'd0, log_addr[base]}, 64'h1000);
      chk("wr0_data", {32'd0, log_data[base]}, 64'hDEADBEEF);
      chk("wr0_we",   {63'd0, log_we[base]}, 64'd1);
      chk("wr1_addr", {32'd0, log_addr[base+1]}, 64'h1004);
      chk("wr1_data", {32'd0, log_data[base+1]}, 64'hCAFEF00D);
      chk("wr1_we",   {63'd0, log_we[base+1]}, 64'd1);
    end
    chk("wr_dout",  rx[63:0], 64'd0);
    chk("wr_addr_after", {32'd0, bus_addr}, 64'h1008);

    // Unknown command drains
    base = log_addr.size();
    spi_frame({24'd0, 8'h55, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 104, rx);
    chk("bad_cmd_cnt",  64'(log_addr.size() - base), 64'd0);
    chk("bad_cmd_dout", rx[63:0], 64'd0);
    chk("bad_cmd_req",  {63'd0, bus_req}, 64'd0);

    // Aborted write, then a clean one
    base = log_addr.size();
    spi_frame({68'd0, 8'h02, 32'h0000_0040, 20'hABCDE}, 60, rx);
    chk("abort_cnt", 64'(log_addr.size() - base), 64'd0);
    spi_frame({56'd0, 8'h02, 32'h0000_0000, 32'h0000_0001}, 72, rx);
    chk("after_abort_cnt", 64'(log_addr.size() - base), 64'd1);
    if (log_addr.size() >= base + 1) begin
      chk("after_abort_addr", {32'd0, log_addr[base]}, 64'h0);
      chk("after_abort_data", {32'd0, log_data[base]}, 64'h1);
    end

    // Reset in the middle of a frame
    base = log_addr.size();
    spi_cs = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits({100'd0, 8'h02, 20'h00001}, 28, rx);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    spi_bits({84'd0, 12'h234, 32'h5555_AAAA}, 44, rx);
    repeat (H) @(negedge clk);
    spi_cs = 1'b1;
    repeat (4 * H) @(negedge clk);
    chk("midrst_cnt",  64'(log_addr.size() - base), 64'd0);
    chk("midrst_addr", {32'd0, bus_addr}, 64'd0);
    chk("midrst_req",  {63'd0, bus_req}, 64'd0);

    // Address wrap
    base = log_addr.size();
    spi_frame({24'd0, 8'h02, 32'hFFFF_FFFC, 64'h11111111_22222222}, 104, rx);
    chk("wrap_cnt", 64'(log_addr.size() - base), 64'd2);
    if (log_addr.size() >= base + 2) begin
      chk("wrap0_addr", {32'd0, log_addr[base]}, 64'hFFFF_FFFC);
      chk("wrap1_addr", {32'd0, log_addr[base+1]}, 64'h0);
      chk("wrap1_data", {32'd0, log_data[base+1]}, 64'h22222222);
    end
    chk("wrap_addr_after", {32'd0, bus_addr}, 64'h4);

`ifdef SPI_SLAVE_READ_EN
    base = log_addr.size();
    spi_frame({24'd0, 8'h0B, 32'h0000_2000, 64'd0}, 104, rx);
    chk("rd_data",  rx[63:0], 64'h12345678_9ABCDEF0);
    chk("rd_hdr",   {24'd0, rx[103:64]}, 64'd0);
    chk("rd_late0", {63'd0, rd_late}, 64'd0);
    if (log_addr.size() >= base + 2) begin
      chk("rd0_addr", {32'd0, log_addr[base]}, 64'h2000);
      chk("rd0_we",   {63'd0, log_we[base]}, 64'd0);
      chk("rd1_addr", {32'd0, log_addr[base+1]}, 64'h2004);
    end else chk("rd_cnt", 64'(log_addr.size() - base), 64'd2);

    rd_idx = 3;
    late_next = 1'b1;
    spi_frame({24'd0, 8'h0B, 32'h0000_3000, 64'd0}, 104, rx);
    chk("late_data", rx[63:0], 64'h00000000_0F0F0F0F);
    chk("late_flag", {63'd0, rd_late}, 64'd1);
`else
    base = log_addr.size();
    spi_frame({24'd0, 8'h0B, 32'h0000_2000, 64'd0}, 104, rx);
    chk("rd_off_cnt",  64'(log_addr.size() - base), 64'd0);
    chk("rd_off_dout", rx[63:0], 64'd0);
    chk("rd_off_late", {63'd0, rd_late}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
